cnf_image_loader: RTL and testbench
===================================

// Module: cnf_image_loader
// PURPOSE
//  Upstream sequencer for the BCP top level: accepts a tagged CNF image stream from the host and replays it as
//  node_in/dummy_ptr/change_eng per engine, then initial unit literals on mem2uca with mem2uca_done.
//  Holds BCP halted during load, then watches conflict/stall and reports a sticky run result to the host.
// PARAMETERS
//  NUM_ENGINE   4    engines to fill; one ENG_END tag closes each
//  DATA_W       64   img_data width; equals node_t width
//  PTR_W        32   dummy_entry_t width (img_data[PTR_W-1:0])
//  LIT_W        16   lit_t width (img_data[LIT_W-1:0])
//  SETTLE_CYC   4    consecutive stall cycles that declare a fixed point
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  img_valid      in   1       host word valid
//  img_ready      out  1       loader accepts word (accept = valid & ready)
//  img_type       in   2       00 CLAUSE, 01 DPTR, 10 ENG_END, 11 UNIT
//  img_data       in   DATA_W  payload
//  img_last       in   1       final word of image; legal only on UNIT or ENG_END
//  node_in        out  DATA_W  clause node to L-buffer
//  node_in_valid  out  1       one-cycle load strobe
//  dummy_ptr      out  PTR_W   dummy pointer entry
//  dummy_ptr_valid out 1       one-cycle load strobe
//  change_eng     out  1       one-cycle strobe: advance L-buffer to next engine
//  mem2uca        out  LIT_W   initial unit literal
//  mem2uca_valid  out  1       one-cycle literal strobe
//  mem2uca_done   out  1       one-cycle strobe: initial literal stream complete
//  halt           out  1       BCP halt; 1 from reset until mem2uca_done
//  conflict       in   1       BCP conflict
//  stall          in   1       BCP global stall
//  run_done       out  1       sticky: result valid
//  run_conflict   out  1       sticky: 1 = conflict, 0 = fixed point
//  load_err       out  1       sticky: malformed image
// BEHAVIOUR
//  Reset: all strobes 0, data outputs 0, halt=1, img_ready=0, run_done=run_conflict=load_err=0, state IDLE, eng_cnt=0.
//  States: IDLE -> LOAD -> UNIT -> RUN -> DONE; ERR absorbing until rst.
//  IDLE: img_ready=0 for one cycle after reset, then -> LOAD.
//  LOAD: img_ready=1. Every output is registered; an accepted word drives its strobe on the next cycle, exactly 1 cycle.
//   CLAUSE -> node_in/node_in_valid. DPTR -> dummy_ptr/dummy_ptr_valid. ENG_END -> change_eng, eng_cnt++.
//   ENG_END with eng_cnt==NUM_ENGINE-1 -> UNIT (no change_eng for last engine).
//   UNIT or img_last while still in LOAD -> ERR.
//  UNIT: img_ready=1; UNIT word -> mem2uca/mem2uca_valid. Other types -> ERR.
//   img_last on the accepted UNIT word (or on the final ENG_END for an image with no units) -> mem2uca_done
//   one cycle after the last literal strobe, never in the same cycle as one. halt deasserts in that same cycle -> RUN.
//  RUN: img_ready=0; halt=0. conflict=1 in any cycle -> run_done=1, run_conflict=1 next cycle -> DONE.
//   stall high for SETTLE_CYC consecutive cycles -> run_done=1, run_conflict=0; the stall counter clears on any stall=0.
//   conflict takes priority over a stall count completing in the same cycle.
//  DONE: outputs sticky, halt=1, img_ready=0. Only rst restarts the sequence.
//  ERR: load_err=1, halt=1, img_ready=0, no further strobes.
//  img_valid without ready: word held by host, not consumed. Back-to-back accepts at 1 word/cycle required.
//  rst mid-load or mid-run: every output returns to its reset value next cycle; partial image discarded.
//  Upper unused bits of node_in/dummy_ptr/mem2uca are driven from the matching img_data bits (no masking).
// TESTING
//  NUM_ENGINE=2: C,C,D,END,C,D,END,U(0x0005,last) -> 2 node strobes, 1 ptr, 1 change_eng, node, ptr,
//   mem2uca=0x0005 then done; halt falls with done.
//  After load, stall=1 for 4 cycles -> run_done=1, run_conflict=0 on cycle 5; stall dropped at cycle 3 restarts count.
//  After load, conflict pulse and 4th stall cycle together -> run_done=1, run_conflict=1.
//  UNIT word before final ENG_END -> load_err=1 next cycle; img_ready=0; no mem2uca_valid.
//  img_valid toggled randomly with 20 words -> strobe order and payloads match input order exactly.
//  rst asserted mid-UNIT -> halt=1, all strobes 0; a fresh image then loads correctly.

Source files
------------

// File: rtl/cnf_image_loader.sv
// Replays a tagged CNF image from the host into the BCP engines, then releases BCP and reports a sticky result.
// All outputs are registered: an accepted word strobes one cycle later; img_ready drops on error, on completion and outside the load phases.
module cnf_image_loader #(
   parameter int NUM_ENGINE = 4,
   parameter int DATA_W     = 64,
   parameter int PTR_W      = 32,
   parameter int LIT_W      = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              img_valid,
   output logic              img_ready,
   input  logic [1:0]        img_type,
   input  logic [DATA_W-1:0] img_data,
   input  logic              img_last,
   output logic [DATA_W-1:0] node_in,
   output logic              node_in_valid,
   output logic [PTR_W-1:0]  dummy_ptr,
   output logic              dummy_ptr_valid,
   output logic              change_eng,
   output logic [LIT_W-1:0]  mem2uca,
   output logic              mem2uca_valid,
   output logic              mem2uca_done,
   output logic              halt,
   input  logic              conflict,
   input  logic              stall,
   output logic              run_done,
   output logic              run_conflict,
   output logic              load_err
);

   localparam int ECW = $clog2(NUM_ENGINE + 1);
   localparam int SCW = $clog2(SETTLE_CYC + 1);
   localparam logic [ECW-1:0] ENG_LAST    = ECW'(NUM_ENGINE - 1);
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

   localparam logic [1:0] T_CLAUSE  = 2'b00;
   localparam logic [1:0] T_DPTR    = 2'b01;
   localparam logic [1:0] T_ENG_END = 2'b10;
   localparam logic [1:0] T_UNIT    = 2'b11;

   // S_FIN is the gap cycle that keeps mem2uca_done one cycle behind the last literal strobe.
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_UNIT, S_FIN, S_RUN, S_DONE, S_ERR
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [ECW-1:0] eng_cnt;
   logic [SCW-1:0] stall_cnt;
   logic [SCW-1:0] stall_cnt_nxt;
   logic           acc;
   logic           node_stb;
   logic           ptr_stb;
   logic           chg_stb;
   logic           uca_stb;
   logic           done_stb;
   logic           ready_nxt;
   logic           halt_nxt;
   logic           load_err_nxt;
   logic           run_done_nxt;
   logic           run_conflict_nxt;

   assign acc = img_valid & img_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         eng_cnt         <= '0;
         stall_cnt       <= '0;
         img_ready       <= 1'b0;
         node_in         <= '0;
         node_in_valid   <= 1'b0;
         dummy_ptr       <= '0;
         dummy_ptr_valid <= 1'b0;
         change_eng      <= 1'b0;
         mem2uca         <= '0;
         mem2uca_valid   <= 1'b0;
         mem2uca_done    <= 1'b0;
         halt            <= 1'b1;
         run_done        <= 1'b0;
         run_conflict    <= 1'b0;
         load_err        <= 1'b0;
      end else begin
         state           <= state_nxt;
         stall_cnt       <= stall_cnt_nxt;
         img_ready       <= ready_nxt;
         node_in_valid   <= node_stb;
         dummy_ptr_valid <= ptr_stb;
         change_eng      <= chg_stb;
         mem2uca_valid   <= uca_stb;
         mem2uca_done    <= done_stb;
         halt            <= halt_nxt;
         run_done        <= run_done_nxt;
         run_conflict    <= run_conflict_nxt;
         load_err        <= load_err_nxt;
         if (chg_stb)
            eng_cnt <= eng_cnt + 1'b1;
         if (node_stb)
            node_in <= img_data;
         if (ptr_stb)
            dummy_ptr <= img_data[PTR_W-1:0];
         if (uca_stb)
            mem2uca <= img_data[LIT_W-1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: state_nxt = S_LOAD;
         S_LOAD: begin
            if (acc) begin
               unique case (img_type)
                  T_CLAUSE, T_DPTR: if (img_last) state_nxt = S_ERR;
                  T_ENG_END: begin
                     if (eng_cnt == ENG_LAST)
                        state_nxt = img_last ? S_FIN : S_UNIT;
                     else if (img_last)
                        state_nxt = S_ERR;
                  end
                  default: state_nxt = S_ERR;
               endcase
            end
         end
         S_UNIT: begin
            if (acc) begin
               if (img_type != T_UNIT)
                  state_nxt = S_ERR;
               else if (img_last)
                  state_nxt = S_FIN;
            end
         end
         S_FIN: state_nxt = S_RUN;
         S_RUN: begin
            if (conflict || (stall && stall_cnt == SETTLE_LAST))
               state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_DONE;
         default: state_nxt = S_ERR;
      endcase
   end

   always_comb begin
      node_stb         = 1'b0;
      ptr_stb          = 1'b0;
      chg_stb          = 1'b0;
      uca_stb          = 1'b0;
      done_stb         = (state == S_FIN);
      ready_nxt        = (state_nxt == S_LOAD) || (state_nxt == S_UNIT);
      halt_nxt         = (state_nxt != S_RUN);
      load_err_nxt     = (state_nxt == S_ERR);
      run_done_nxt     = run_done || ((state == S_RUN) && (state_nxt == S_DONE));
      run_conflict_nxt = run_conflict || ((state == S_RUN) && conflict);
      stall_cnt_nxt    = '0;
      // Malformed words never strobe; the error state swallows them.
      if (acc && state == S_LOAD && !img_last) begin
         node_stb = (img_type == T_CLAUSE);
         ptr_stb  = (img_type == T_DPTR);
         chg_stb  = (img_type == T_ENG_END) && (eng_cnt != ENG_LAST);
      end
      if (acc && state == S_UNIT)
         uca_stb = (img_type == T_UNIT);
      if (state == S_RUN && stall)
         stall_cnt_nxt = stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_cnf_image_loader.sv
// Directed + randomized bench for cnf_image_loader (NUM_ENGINE=2) against a word-list reference model.
module tb_cnf_image_loader;
   localparam int NENG = 2;
   localparam int SETTLE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        img_valid = 1'b0;
   logic        img_ready;
   logic [1:0]  img_type = 2'b00;
   logic [63:0] img_data = '0;
   logic        img_last = 1'b0;
   logic [63:0] node_in;
   logic        node_in_valid;
   logic [31:0] dummy_ptr;
   logic        dummy_ptr_valid;
   logic        change_eng;
   logic [15:0] mem2uca;
   logic        mem2uca_valid;
   logic        mem2uca_done;
   logic        halt;
   logic        conflict = 1'b0;
   logic        stall = 1'b0;
   logic        run_done;
   logic        run_conflict;
   logic        load_err;

   cnf_image_loader #(.NUM_ENGINE(NENG), .DATA_W(64), .PTR_W(32), .LIT_W(16), .SETTLE_CYC(SETTLE)) dut (
      .clk(clk), .rst(rst), .img_valid(img_valid), .img_ready(img_ready), .img_type(img_type),
      .img_data(img_data), .img_last(img_last), .node_in(node_in), .node_in_valid(node_in_valid),
      .dummy_ptr(dummy_ptr), .dummy_ptr_valid(dummy_ptr_valid), .change_eng(change_eng),
      .mem2uca(mem2uca), .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done), .halt(halt),
      .conflict(conflict), .stall(stall), .run_done(run_done), .run_conflict(run_conflict),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [1:0] t; logic [63:0] d; logic last; } word_t;
   typedef struct packed { logic [2:0] kind; logic [63:0] dat; } ev_t;
   localparam logic [2:0] K_NODE = 3'd0, K_PTR = 3'd1, K_CHG = 3'd2, K_UCA = 3'd3, K_DONE = 3'd4;

   word_t img_q[$];
   ev_t   ev_q[$];
   int    ev_cyc[$];
   ev_t   exp_q[$];
   int    cyc = 0;
   int    halt_fall = -1;
   logic  halt_q = 1'b1;
   int    checks = 0;
   int    errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (node_in_valid)   begin ev_q.push_back('{K_NODE, node_in});        ev_cyc.push_back(cyc); end
      if (dummy_ptr_valid) begin ev_q.push_back('{K_PTR, {32'b0, dummy_ptr}}); ev_cyc.push_back(cyc); end
      if (change_eng)      begin ev_q.push_back('{K_CHG, 64'b0});          ev_cyc.push_back(cyc); end
      if (mem2uca_valid)   begin ev_q.push_back('{K_UCA, {48'b0, mem2uca}}); ev_cyc.push_back(cyc); end
      if (mem2uca_done)    begin ev_q.push_back('{K_DONE, 64'b0});         ev_cyc.push_back(cyc); end
      if (halt_q && !halt) halt_fall = cyc;
      halt_q = halt;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the image by the format rules and list the strobes it must produce.
   task automatic build_expected(output bit err);
      int eng = 0;
      bit units = 0;
      err = 0;
      exp_q.delete();
      foreach (img_q[i]) begin
         word_t w = img_q[i];
         if (!units) begin
            if (w.t == 2'b11 || (w.last && w.t != 2'b10)) begin err = 1; break; end
            if (w.t == 2'b00) exp_q.push_back('{K_NODE, w.d});
            else if (w.t == 2'b01) exp_q.push_back('{K_PTR, {32'b0, w.d[31:0]}});
            else if (eng == NENG - 1) begin
               units = 1;
               if (w.last) begin exp_q.push_back('{K_DONE, 64'b0}); break; end
            end else begin
               if (w.last) begin err = 1; break; end
               exp_q.push_back('{K_CHG, 64'b0});
               eng++;
            end
         end else begin
            if (w.t != 2'b11) begin err = 1; break; end
            exp_q.push_back('{K_UCA, {48'b0, w.d[15:0]}});
            if (w.last) begin exp_q.push_back('{K_DONE, 64'b0}); break; end
         end
      end
   endtask

   task automatic check_events(input string tag);
      bit err;
      int n;
      build_expected(err);
      chk({tag, "_count"}, 64'(ev_q.size()), 64'(exp_q.size()));
      n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_kind%0d", tag, i), 64'(ev_q[i].kind), 64'(exp_q[i].kind));
         chk($sformatf("%s_dat%0d", tag, i), ev_q[i].dat, exp_q[i].dat);
      end
      if (!err && ev_q.size() == exp_q.size() && n > 0) begin
         chk({tag, "_halt_with_done"}, 64'(halt_fall), 64'(ev_cyc[n-1]));
         if (n > 1 && exp_q[n-2].kind == K_UCA)
            chk({tag, "_done_after_lit"}, 64'(ev_cyc[n-1]), 64'(ev_cyc[n-2] + 1));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      img_valid = 1'b0; conflict = 1'b0; stall = 1'b0;
      @(posedge clk); #1;
      chk("rst_halt", 64'(halt), 64'd1);
      chk("rst_ready", 64'(img_ready), 64'd0);
      chk("rst_strobes", 64'({node_in_valid, dummy_ptr_valid, change_eng, mem2uca_valid, mem2uca_done}), 64'd0);
      chk("rst_data", node_in | 64'(dummy_ptr) | 64'(mem2uca), 64'd0);
      chk("rst_sticky", 64'({run_done, run_conflict, load_err}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ev_q.delete(); ev_cyc.delete(); halt_fall = -1;
      chk("idle_ready", 64'(img_ready), 64'd0);
      @(posedge clk); #1;
      chk("load_ready", 64'(img_ready), 64'd1);
   endtask

   task automatic send_image(input bit rnd);
      int idx = 0;
      int cycles = 0;
      bit accepted;
      while (idx < img_q.size() && cycles < 400) begin
         img_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         img_type  = img_q[idx].t;
         img_data  = img_q[idx].d;
         img_last  = img_q[idx].last;
         @(negedge clk);
         accepted = img_valid && img_ready;
         @(posedge clk); #1;
         if (accepted) idx++;
         cycles++;
      end
      img_valid = 1'b0; img_last = 1'b0;
      chk("send_all_words", 64'(idx), 64'(img_q.size()));
   endtask

   task automatic wait_run();
      int n = 0;
      while (halt && n < 30) begin @(posedge clk); #1; n++; end
      chk("enter_run", 64'(halt), 64'd0);
   endtask

   // Expected completion step comes from counting runs of stall, conflict winning.
   task automatic run_vec(input bit [15:0] sv, input bit [15:0] cv, input int len);
      int exp_idx = 1000;
      int cnt = 0;
      bit exp_conf = 0;
      for (int i = 0; i < len; i++) begin
         if (cv[i]) begin exp_idx = i; exp_conf = 1; break; end
         cnt = sv[i] ? cnt + 1 : 0;
         if (cnt == SETTLE) begin exp_idx = i; break; end
      end
      for (int i = 0; i < len; i++) begin
         stall = sv[i]; conflict = cv[i];
         @(posedge clk); #1;
         chk($sformatf("run_done_step%0d", i), 64'(run_done), 64'(i >= exp_idx));
      end
      stall = 1'b0; conflict = 1'b1;
      @(posedge clk); #1;
      conflict = 1'b0;
      chk("run_conflict", 64'(run_conflict), 64'(exp_conf));
      chk("done_halt", 64'(halt), 64'd1);
      chk("done_ready", 64'(img_ready), 64'd0);
   endtask

   function automatic word_t mk(input logic [1:0] t, input logic [63:0] d, input logic last);
      word_t w;
      w.t = t; w.d = d; w.last = last;
      return w;
   endfunction

   task automatic gen_random(input int b0, input int b1, input int nu);
      img_q.delete();
      for (int e = 0; e < 2; e++) begin
         for (int i = 0; i < ((e == 0) ? b0 : b1); i++)
            img_q.push_back(mk(2'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0));
         img_q.push_back(mk(2'b10, {$urandom, $urandom}, (e == 1) && (nu == 0)));
      end
      for (int i = 0; i < nu; i++)
         img_q.push_back(mk(2'b11, {$urandom, $urandom}, i == nu - 1));
   endtask

   initial begin
      // Directed image from the datasheet example, then settle with a restarted stall run.
      do_reset();
      img_q.delete();
      img_q.push_back(mk(2'b00, 64'h1111_0000_0000_0001, 1'b0));
      img_q.push_back(mk(2'b00, 64'h2222_0000_0000_0002, 1'b0));
      img_q.push_back(mk(2'b01, 64'hdead_beef_0000_0033, 1'b0));
      img_q.push_back(mk(2'b10, 64'h0, 1'b0));
      img_q.push_back(mk(2'b00, 64'h4444_0000_0000_0004, 1'b0));
      img_q.push_back(mk(2'b01, 64'h0000_0000_0000_0055, 1'b0));
      img_q.push_back(mk(2'b10, 64'h0, 1'b0));
      img_q.push_back(mk(2'b11, 64'hffff_0000_0000_0005, 1'b1));
      send_image(1'b0);
      wait_run();
      run_vec(16'b1111011, 16'b0, 8);
      check_events("directed");

      // Random 20-word image with gapped valid; conflict lands with the 4th stall.
      do_reset();
      gen_random(8, 7, 3);
      send_image(1'b1);
      wait_run();
      run_vec(16'b1111, 16'b1000, 5);
      check_events("random20");

      // UNIT word before the final ENG_END.
      do_reset();
      img_q.delete();
      img_q.push_back(mk(2'b00, 64'h77, 1'b0));
      img_q.push_back(mk(2'b11, 64'h9, 1'b0));
      send_image(1'b0);
      chk("err_flag", 64'(load_err), 64'd1);
      chk("err_ready", 64'(img_ready), 64'd0);
      img_valid = 1'b1; img_type = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      img_valid = 1'b0;
      chk("err_halt", 64'(halt), 64'd1);
      check_events("err");

      // Reset in the middle of the unit phase, then a fresh image without units.
      do_reset();
      gen_random(3, 2, 3);
      void'(img_q.pop_back());
      void'(img_q.pop_back());
      send_image(1'b0);
      do_reset();
      gen_random(4, 5, 0);
      send_image(1'b1);
      wait_run();
      run_vec(16'b0, 16'b0100, 4);
      check_events("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
